// File: rtl/call_stack_pkg.sv
// Shared constants for the call_stack return-address stack: default sizes,
// occupancy-counter width derivation and the per-cycle operation encoding.
package call_stack_pkg;

  localparam int CS_ADDR_W = 12;
  localparam int CS_DEPTH  = 31;
  // One spare bit above what 0..DEPTH needs, so count+1 is never truncated.
  localparam int CS_PTR_W  = $clog2(CS_DEPTH + 1) + 1;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

endpackage

// File: rtl/call_stack_mem.sv
// DEPTH x ADDR_W register file for the call stack: one synchronous write
// port, one asynchronous read port, contents never reset.
module call_stack_mem
  import call_stack_pkg::*;
#(
  parameter int ADDR_W = CS_ADDR_W,
  parameter int DEPTH  = CS_DEPTH,
  parameter int IDX_W  = $clog2(CS_DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [ADDR_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [ADDR_W-1:0] o_rdata
);

  logic [ADDR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack feeding the next-PC mux. Optional macro
// CALL_STACK_WRAP_EN selects circular (overwrite-oldest) mode on overflow.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int ADDR_W = CS_ADDR_W,
  parameter int DEPTH  = CS_DEPTH,
  parameter int PTR_W  = CS_PTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stk_push,
  input  logic              stk_pop,
  input  logic [ADDR_W-1:0] stk_push_addr,
  output logic [ADDR_W-1:0] stk_top,
  output logic [PTR_W-1:0]  stk_count,
  output logic              stk_empty,
  output logic              stk_full,
  output logic              stk_overflow,
  output logic              stk_underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
  localparam logic [PTR_W-1:0] TWO_P   = PTR_W'(2);

  logic [PTR_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_top;
  logic              r_ovf;
  logic              r_unf;

  op_e               w_op;
  logic              w_empty;
  logic              w_full;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [IDX_W-1:0]  w_raddr;
  logic [PTR_W-1:0]  w_rlog;
  logic [ADDR_W-1:0] w_rdata;
  logic [IDX_W-1:0]  w_base;

  // Map a logical stack index (0 = oldest) onto a storage slot, folding the
  // base-pointer offset back into 0..DEPTH-1 without a modulo operator.
  function automatic logic [IDX_W-1:0] phys_idx(input logic [IDX_W-1:0] base,
                                                input logic [PTR_W-1:0] lidx);
    logic [PTR_W:0] sum;
    sum = (PTR_W + 1)'(base) + {1'b0, lidx};
    if (sum >= {1'b0, DEPTH_P}) begin
      sum = sum - {1'b0, DEPTH_P};
    end
    return sum[IDX_W-1:0];
  endfunction

`ifdef CALL_STACK_WRAP_EN
  logic [IDX_W-1:0] r_base;

  function automatic logic [IDX_W-1:0] base_inc(input logic [IDX_W-1:0] base);
    return (base == IDX_W'(DEPTH - 1)) ? '0 : base + IDX_W'(1);
  endfunction

  assign w_base = r_base;
`else
  assign w_base = '0;
`endif

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_P);

  // A simultaneous push/pop on an empty stack degenerates to a plain push.
  always_comb begin
    w_op = OP_IDLE;
    if (stk_push && stk_pop) begin
      w_op = w_empty ? OP_PUSH : OP_REPLACE;
    end else if (stk_push) begin
      w_op = OP_PUSH;
    end else if (stk_pop) begin
      w_op = OP_POP;
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_we    = 1'b1;
          w_waddr = phys_idx(w_base, r_count);
        end
`ifdef CALL_STACK_WRAP_EN
        else begin
          // Slot at the base pointer holds the oldest entry; reuse it.
          w_we    = 1'b1;
          w_waddr = w_base;
        end
`endif
      end
      OP_REPLACE: begin
        w_we    = 1'b1;
        w_waddr = phys_idx(w_base, r_count - ONE_P);
      end
      default: ;
    endcase
    if (reset) begin
      w_we = 1'b0;
    end
  end

  // Entry that becomes the new top after a pop (second from the top).
  assign w_rlog  = (r_count >= TWO_P) ? (r_count - TWO_P) : '0;
  assign w_raddr = phys_idx(w_base, w_rlog);

  call_stack_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (stk_push_addr),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_top   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          if (!w_full) begin
            r_count <= r_count + ONE_P;
            r_top   <= stk_push_addr;
          end else begin
            r_ovf <= 1'b1;
`ifdef CALL_STACK_WRAP_EN
            r_top <= stk_push_addr;
`endif
          end
        end
        OP_POP: begin
          if (!w_empty) begin
            r_count <= r_count - ONE_P;
            r_top   <= (r_count >= TWO_P) ? w_rdata : '0;
          end else begin
            r_unf <= 1'b1;
          end
        end
        OP_REPLACE: begin
          r_top <= stk_push_addr;
        end
        default: ;
      endcase
    end
  end

`ifdef CALL_STACK_WRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base <= '0;
    end else if (w_op == OP_PUSH && w_full) begin
      r_base <= base_inc(r_base);
    end
  end
`endif

  assign stk_top       = r_top;
  assign stk_count     = r_count;
  assign stk_empty     = w_empty;
  assign stk_full      = w_full;
  assign stk_overflow  = r_ovf;
  assign stk_underflow = r_unf;

endmodule

// File: tb/tb_call_stack.sv
// Scoreboard bench for call_stack: a queue-based stack model predicts each
// cycle's outputs; a monitor compares them one clock edge later.
module tb_call_stack;
  import call_stack_pkg::*;

  localparam int AW = CS_ADDR_W;
  localparam int DP = CS_DEPTH;
  localparam int PW = CS_PTR_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stk_push = 1'b0;
  logic          stk_pop = 1'b0;
  logic [AW-1:0] stk_push_addr = '0;
  logic [AW-1:0] stk_top;
  logic [PW-1:0] stk_count;
  logic          stk_empty, stk_full, stk_overflow, stk_underflow;

  call_stack dut (
    .clk           (clk),
    .reset         (reset),
    .stk_push      (stk_push),
    .stk_pop       (stk_pop),
    .stk_push_addr (stk_push_addr),
    .stk_top       (stk_top),
    .stk_count     (stk_count),
    .stk_empty     (stk_empty),
    .stk_full      (stk_full),
    .stk_overflow  (stk_overflow),
    .stk_underflow (stk_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int top;
    int cnt;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t exp_q[$];
  int   model_stk[$];
  bit   m_ovf, m_unf;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ops[4];
  bit   stim_done = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus and record what the outputs must be after it.
  task automatic step(input bit rst, input bit psh, input bit pp, input int addr);
    op_e  op;
    exp_t e;
    @(negedge clk);
    reset         = rst;
    stk_push      = psh;
    stk_pop       = pp;
    stk_push_addr = AW'(addr);
    if (rst) begin
      model_stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (psh && pp) op = (model_stk.size() == 0) ? OP_PUSH : OP_REPLACE;
      else if (psh)  op = OP_PUSH;
      else if (pp)   op = OP_POP;
      else           op = OP_IDLE;
      n_ops[op]++;
      case (op)
        OP_PUSH: begin
          if (model_stk.size() < DP) begin
            model_stk.push_back(addr);
          end else begin
            m_ovf = 1;
`ifdef CALL_STACK_WRAP_EN
            void'(model_stk.pop_front());
            model_stk.push_back(addr);
`endif
          end
        end
        OP_POP: begin
          if (model_stk.size() > 0) void'(model_stk.pop_back());
          else m_unf = 1;
        end
        OP_REPLACE: model_stk[model_stk.size() - 1] = addr;
        default: ;
      endcase
    end
    e.top = (model_stk.size() > 0) ? model_stk[model_stk.size() - 1] : 0;
    e.cnt = model_stk.size();
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  // Monitor: each cycle with a pending expectation is checked after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stk_top", int'(stk_top), e.top);
        chk("stk_count", int'(stk_count), e.cnt);
        chk("stk_empty", int'(stk_empty), int'(e.cnt == 0));
        chk("stk_full", int'(stk_full), int'(e.cnt == DP));
        chk("stk_overflow", int'(stk_overflow), int'(e.ovf));
        chk("stk_underflow", int'(stk_underflow), int'(e.unf));
      end
    end
  end

  initial begin
    int r;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    step(0, 1, 0, 'h101);
    step(0, 1, 0, 'h202);
    step(0, 1, 0, 'h303);
    repeat (3) step(0, 0, 1, 0);

    step(0, 1, 0, 'h055);
    step(0, 1, 0, 'h0AA);
    step(0, 1, 1, 'h0BB);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    step(0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    for (int i = 1; i <= DP; i++) step(0, 1, 0, i);
    step(0, 1, 0, 'h7FF);
    step(0, 1, 1, 'h3C3);
    for (int i = 0; i <= DP; i++) step(0, 0, 1, 0);
    step(1, 0, 0, 0);

    step(0, 1, 0, 'h123);
    step(0, 1, 0, 'h456);
    step(1, 1, 0, 'hABC);
    step(0, 1, 0, 'h789);
    step(1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0)       step(1, $urandom_range(0, 1), 0, $urandom);
      else if (r < 95)  step(0, 1, 0, $urandom & 'hFFF);
      else if (r < 165) step(0, 0, 1, 0);
      else if (r < 185) step(0, 1, 1, $urandom & 'hFFF);
      else              step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    stim_done = 1'b1;
  end

  initial begin
    int guard = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    if (n_ops[OP_REPLACE] == 0 || n_ops[OP_POP] == 0) begin
      n_err++;
      $display("FAIL op_mix: replace=%0d pop=%0d, expected both nonzero",
               n_ops[OP_REPLACE], n_ops[OP_POP]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Subroutine return-address stack for the pico processor's program-counter path.
- Sits directly upstream of the 12-bit next-PC 2:1 mux: its registered top-of-stack output drives the mux's data1 input, and the decode selects it on RETURN.
- CALL pushes the return address supplied by the PC stage; RETURN pops.

Parameters:
- ADDR_W, 12, width of stored addresses; equals the PC/mux data width.
- DEPTH, 31, number of stack entries; any value 2..63 is legal.
- PTR_W, 6, occupancy counter width; must satisfy 2**PTR_W > DEPTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stk_push  in  1  push stk_push_addr this cycle (CALL).
- stk_pop  in  1  pop the top entry this cycle (RETURN).
- stk_push_addr  in  ADDR_W  return address to store.
- stk_top  out  ADDR_W  registered current top entry; feeds next-PC mux data1.
- stk_count  out  PTR_W  current number of valid entries, 0..DEPTH.
- stk_empty  out  1  stk_count == 0.
- stk_full  out  1  stk_count == DEPTH.
- stk_overflow  out  1  sticky; push attempted while full.
- stk_underflow  out  1  sticky; pop attempted while empty.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high, sampled on the rising edge of clk. It has priority over push and pop.
  - Reset values: stk_count=0, stk_top=0, stk_empty=1, stk_full=0, stk_overflow=0, stk_underflow=0.
  - Storage array contents are not reset. Reset during a sequence discards it; the first post-reset push lands at entry 0.
- Latency: every output updates on the edge that samples the request. stk_top is valid one cycle after the push/pop and is never combinational from the inputs.
- Push only, not full: mem[count] <= addr; stk_top <= addr; count += 1.
- Pop only, not empty:
  - count -= 1.
  - stk_top <= mem[count-2] when count >= 2, else 0.
- Push and pop in the same cycle (replace top):
  - Requires count >= 1: mem[count-1] <= addr; stk_top <= addr; count is unchanged.
  - If count == 0: treated as a push alone, and stk_underflow is not set.
  - If count == DEPTH: treated as a replace (legal); stk_overflow is not set.
- Push while full (no pop): governed by the optional feature below.
- Pop while empty (no push): state unchanged, stk_top stays 0, stk_underflow <= 1.
- Sticky flags clear only on reset.
- Arithmetic:
  - Indices are PTR_W bits and never wrap modulo 2**PTR_W.
  - Storage indices stay in 0..DEPTH-1 in all cases.
- No state machine beyond the occupancy counter. Each cycle is one of four decoded ops: IDLE, PUSH, POP, REPLACE.

Optional Feature:
- Macro: CALL_STACK_WRAP_EN.
- Defined (circular mode, PicoBlaze-compatible):
  - A push while full overwrites the oldest entry, and stk_top <= addr.
  - count stays DEPTH and stk_overflow <= 1.
  - Storage becomes a circular buffer with a base pointer. Pops return the newest entries; after DEPTH pops the stack is empty.
- Undefined (default, saturating mode):
  - A push while full is dropped: storage, stk_top and count are unchanged.
  - stk_overflow <= 1.

Decomposition:
- Package call_stack_pkg:
  - Holds the ADDR_W and DEPTH defaults and the PTR_W derivation.
  - Holds the op encoding constants OP_IDLE, OP_PUSH, OP_POP and OP_REPLACE, used by the RTL and the bench scoreboard.
- Sub-module call_stack_mem: DEPTH x ADDR_W register file with one write port and one asynchronous read port, no reset. call_stack holds the counter, the base pointer (wrap mode), the top register and the flags.

Test Plan:
- Reset then idle 3 cycles -> stk_top=0x000, count=0, empty=1, full=0, both sticky flags 0.
- Push 0x101, 0x202, 0x303 on consecutive cycles, then 3 pops:
  - stk_top after each push: 0x101, 0x202, 0x303.
  - stk_top after each pop: 0x202, 0x101, 0x000.
  - count ends at 0 and empty=1.
- With count=2 (top 0x0AA), push 0x0BB and pop together -> stk_top=0x0BB, count=2. One further pop -> stk_top = the entry below (the first value pushed).
- Push 0x001..0x01F (31 pushes) so full=1, then push 0x7FF:
  - Default build: stk_top=0x01F, count=31, overflow=1.
  - CALL_STACK_WRAP_EN build: stk_top=0x7FF and overflow=1; 31 pops then return 0x01F..0x002, then empty.
- Pop on an empty stack -> underflow=1, count=0, stk_top=0x000. Flag persists through 5 idle cycles. Reset clears it.
- Push 0x123, 0x456, then assert reset together with stk_push=1 -> count=0, stk_top=0, push ignored. Next push 0x789 -> stk_top=0x789, count=1.
